// File: rtl/cfo_rotator.sv
// ============================================================================
// cfo_rotator : NCO-driven derotator removing estimated CFO, 5-cycle latency
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cfo_rotator #(
   parameter int IN_DW  = 32,
   parameter int OUT_DW = 32,
   parameter int DDS_DW = 20,
   parameter int LUT_DW = 10,
   parameter int SIN_DW = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [IN_DW-1:0]  s_axis_in_tdata,
   input  logic              s_axis_in_tvalid,
   input  logic [DDS_DW-1:0] CFO_DDS_inc_i,
   input  logic              CFO_valid_i,
   input  logic              phase_clear_i,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tvalid,
   output logic [DDS_DW-1:0] inc_o
);

   localparam int  IW    = IN_DW / 2;
   localparam int  OW    = OUT_DW / 2;
   localparam int  MW    = IW + SIN_DW;
   localparam int  PW    = MW + 1;
   localparam int  TAB_N = 2 ** LUT_DW;
   localparam real PI    = 3.14159265358979323846;
   localparam real AMP   = (2.0 ** (SIN_DW - 1)) - 1.0;
   localparam logic signed [PW-1:0] SAT_HI = PW'((64'sd1 <<< (OW - 1)) - 64'sd1);
   localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

   // Round-half-away-from-zero cos/sin table, folded to constants at elaboration
   logic signed [SIN_DW-1:0] cos_tab [TAB_N];
   logic signed [SIN_DW-1:0] sin_tab [TAB_N];

   for (genvar k = 0; k < TAB_N; k++) begin : g_lut
      localparam real ANG = 2.0 * PI * k / TAB_N;
      localparam real CR  = AMP * $cos(ANG);
      localparam real SR  = AMP * $sin(ANG);
      localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
      localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
      assign cos_tab[k] = SIN_DW'(CI);
      assign sin_tab[k] = SIN_DW'(SI);
   end

   function automatic logic signed [MW-1:0] f_mul(input logic signed [IW-1:0] a,
                                                  input logic signed [SIN_DW-1:0] b);
      logic signed [MW-1:0] ae;
      logic signed [MW-1:0] be;
      ae = MW'(a);
      be = MW'(b);
      return ae * be;
   endfunction

   function automatic logic [OW-1:0] f_sat(input logic signed [PW-1:0] v);
      if (v > SAT_HI) begin
         return SAT_HI[OW-1:0];
      end else if (v < SAT_LO) begin
         return SAT_LO[OW-1:0];
      end
      return v[OW-1:0];
   endfunction

   logic [DDS_DW-1:0] inc_q, inc_d;
   logic [DDS_DW-1:0] phase_acc_q, phase_acc_d;
   logic [LUT_DW-1:0] addr_d;

   logic                     s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q, out_vld_q;
   logic [IN_DW-1:0]         s1_data_q, s2_data_q, s3_data_q;
   logic [LUT_DW-1:0]        s1_addr_q;
   logic signed [SIN_DW-1:0] s2_cos_q, s2_sin_q, s3_cos_q, s3_sin_q;
   logic signed [MW-1:0]     p_rc_q, p_is_q, p_rs_q, p_ic_q;
   logic [OUT_DW-1:0]        out_data_q;

   logic signed [PW-1:0] sum_re, sum_im, sh_re, sh_im;

   // A cleared cycle tags its sample with phase 0 and steps from there
   always_comb begin
      inc_d       = inc_q;
      phase_acc_d = phase_acc_q;
      addr_d      = phase_acc_q[DDS_DW-1 -: LUT_DW];
      if (CFO_valid_i) begin
         inc_d = CFO_DDS_inc_i;
      end
      if (phase_clear_i) begin
         addr_d      = '0;
         phase_acc_d = s_axis_in_tvalid ? (-inc_q) : '0;
      end else if (s_axis_in_tvalid) begin
         phase_acc_d = phase_acc_q - inc_q;
      end
   end

   assign sum_re = PW'(p_rc_q) - PW'(p_is_q);
   assign sum_im = PW'(p_rs_q) + PW'(p_ic_q);
   assign sh_re  = sum_re >>> (SIN_DW - 1);
   assign sh_im  = sum_im >>> (SIN_DW - 1);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         inc_q       <= '0;
         phase_acc_q <= '0;
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s3_vld_q    <= 1'b0;
         s4_vld_q    <= 1'b0;
         out_vld_q   <= 1'b0;
         s1_data_q   <= '0;
         s2_data_q   <= '0;
         s3_data_q   <= '0;
         s1_addr_q   <= '0;
         s2_cos_q    <= '0;
         s2_sin_q    <= '0;
         s3_cos_q    <= '0;
         s3_sin_q    <= '0;
         p_rc_q      <= '0;
         p_is_q      <= '0;
         p_rs_q      <= '0;
         p_ic_q      <= '0;
         out_data_q  <= '0;
      end else begin
         inc_q       <= inc_d;
         phase_acc_q <= phase_acc_d;

         s1_vld_q  <= s_axis_in_tvalid;
         s1_data_q <= s_axis_in_tdata;
         s1_addr_q <= addr_d;

         s2_vld_q  <= s1_vld_q;
         s2_data_q <= s1_data_q;
         s2_cos_q  <= cos_tab[s1_addr_q];
         s2_sin_q  <= sin_tab[s1_addr_q];

         s3_vld_q  <= s2_vld_q;
         s3_data_q <= s2_data_q;
         s3_cos_q  <= s2_cos_q;
         s3_sin_q  <= s2_sin_q;

         s4_vld_q <= s3_vld_q;
         p_rc_q   <= f_mul(s3_data_q[IW-1:0],     s3_cos_q);
         p_is_q   <= f_mul(s3_data_q[IN_DW-1:IW], s3_sin_q);
         p_rs_q   <= f_mul(s3_data_q[IW-1:0],     s3_sin_q);
         p_ic_q   <= f_mul(s3_data_q[IN_DW-1:IW], s3_cos_q);

         out_vld_q <= s4_vld_q;
         if (s4_vld_q) begin
            out_data_q <= {f_sat(sh_im), f_sat(sh_re)};
         end
      end
   end

   assign m_axis_out_tdata  = out_data_q;
   assign m_axis_out_tvalid = out_vld_q;
   assign inc_o             = inc_q;

endmodule

`default_nettype wire

// File: doc/cfo_rotator.md
# cfo_rotator

Downstream consumer of the CFO estimator. It takes the DDS phase increment produced by the CFO estimation stage and runs a numerically controlled oscillator from it. It derotates the baseband sample stream by the estimated carrier frequency offset, one sample per clock, with fixed latency. It sits between the CFO estimator and the FFT/demodulation path.

## Interface
Parameters:
- IN_DW, 32, complex input width; {im, re}, each IN_DW/2 signed
- OUT_DW, 32, complex output width; {im, re}, each OUT_DW/2 signed
- DDS_DW, 20, phase accumulator / increment width (2^DDS_DW = 2π)
- LUT_DW, 10, phase bits addressing the cos/sin table
- SIN_DW, 16, signed cos/sin table width

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- s_axis_in_tdata  in  IN_DW  input sample {im, re}
- s_axis_in_tvalid  in  1  input sample valid
- CFO_DDS_inc_i  in  DDS_DW  signed phase increment per sample, from CFO estimator
- CFO_valid_i  in  1  load CFO_DDS_inc_i into increment register
- phase_clear_i  in  1  zero the phase accumulator
- m_axis_out_tdata  out  OUT_DW  derotated sample {im, re}
- m_axis_out_tvalid  out  1  output valid
- inc_o  out  DDS_DW  currently active increment (debug)

## Operation
- inc_r (signed DDS_DW) loads CFO_DDS_inc_i on the clock edge where CFO_valid_i=1. Otherwise it holds.
- phase_acc (unsigned DDS_DW) wraps modulo 2^DDS_DW.
- Each sample with tvalid=1 is tagged with the current phase_acc, φ. Then phase_acc <= phase_acc - inc_r. The new φ is negative-going, so it cancels a positive CFO.
- phase_acc does not advance on cycles with tvalid=0.
- Simultaneous CFO_valid_i and tvalid: the sample uses the current φ. The step applied in that cycle uses the OLD inc_r. The new increment is first applied after the next valid sample.
- phase_clear_i=1: the sample in the same cycle (if valid) uses φ=0, and phase_acc <= -inc_r. Without a valid sample, phase_acc <= 0. phase_clear_i has priority over normal update.
- Table: 2^LUT_DW entries addressed by phase_acc[DDS_DW-1 -: LUT_DW] (truncation, no dither).
  - cos[k] = round(32767·cos(2πk/2^LUT_DW)), scaled to 2^(SIN_DW-1)-1 generally; sin likewise.
  - Built in an initial block. The table may be quarter-wave folded internally if outputs are bit-identical.
- Multiply:
  - y_re = x_re·c − x_im·s
  - y_im = x_re·s + x_im·c
  - Full precision IN_DW/2+SIN_DW+1 bits.
- Scale: arithmetic shift right by SIN_DW-1 (floor), then saturate to signed OUT_DW/2 (±(2^(OUT_DW/2-1)-1) and −2^(OUT_DW/2-1)).
- No backpressure (no tready). Throughput is 1 sample/clk. Bubbles are preserved in order.

## Timing
- Reset (async assert, sync deassert use): m_axis_out_tdata=0, m_axis_out_tvalid=0, inc_o=0, inc_r=0, phase_acc=0, all pipeline valids=0.
- Pipeline, fixed latency 5 cycles from s_axis_in_tvalid to m_axis_out_tvalid:
  - S1: register sample and φ
  - S2: table read (registered)
  - S3: register c, s and sample
  - S4: four products
  - S5: sums, shift, saturate, output register
- m_axis_out_tdata holds its last value when tvalid=0.
- inc_o reflects inc_r one cycle after CFO_valid_i.
- Reset mid-stream: in-flight samples are discarded; tvalid stays 0 until 5 cycles after the first valid input following reset release.
- Wrap-around of phase_acc is silent, with no discontinuity beyond modulo arithmetic.

## Test plan
- inc=0, continuous input re=1000, im=0 -> every output (re=999, im=0), first valid exactly 5 cycles after first input.
- CFO_valid_i with inc=262144 (−π/2 steps), then phase_clear, then 4 valid samples (1000,0) -> outputs (999,0), (0,−1000), (−1000,0), (0,999), repeating with period 4.
- Same as above, but a new inc=0 is loaded in the same cycle as sample 2 -> sample 2 at −π/2, sample 3 at −π, samples 4+ stay at −π: (−1000,0) repeated.
- phase_clear, inc=−131072 (+π/4 steps), input (32767,32767) -> sample 1 (32766,32766); sample 2 re=0, im saturates to 32767.
- Gapped input (valid every 3rd cycle), inc=262144 -> same 4-value sequence as the second case; phase advances only on valid; outputs spaced 3 cycles.
- Assert reset_i asynchronously with 3 samples in flight -> outputs immediately 0, tvalid never asserts for those samples, inc_o=0; after release, a fresh sample produces output at latency 5 with φ=0.
